core_rvfi_trace: RTL and testbench

Trace buffer directly downstream of the core's RVFI output stage. Every retired instruction reported on `rvfi_valid` is tagged with a 64-bit retirement order number and pushed into a DEPTH-entry FIFO. The FIFO drains to a testbench or trace sink over a valid/ready handshake, so a slow consumer never back-pressures the core. Overflow drops are counted and flagged, never silent.

---
 rtl/core_rvfi_trace_if.sv | 65 ++++++
 rtl/core_rvfi_trace.sv | 138 +++++++++++++
 tb/tb_core_rvfi_trace.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/core_rvfi_trace_if.sv
// core_rvfi_trace_if: RVFI retirement inputs and trace-sink handshake bundle.
// Optional PC-continuity status fields exist only when CORE_RVFI_TRACE_PC_CHECK_EN
// is defined.
interface core_rvfi_trace_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
);
    logic                       rvfi_valid;
    logic [ILEN-1:0]            rvfi_insn;
    logic                       rvfi_trap;
    logic                       rvfi_intr;
    logic [XLEN-1:0]            rvfi_pc_rdata;
    logic [XLEN-1:0]            rvfi_pc_wdata;
    logic [4:0]                 rvfi_rd_addr;
    logic [XLEN-1:0]            rvfi_rd_wdata;

    logic                       trc_valid;
    logic                       trc_ready;
    logic [63:0]                trc_order;
    logic [ILEN-1:0]            trc_insn;
    logic                       trc_trap;
    logic                       trc_intr;
    logic [XLEN-1:0]            trc_pc_rdata;
    logic [XLEN-1:0]            trc_pc_wdata;
    logic [4:0]                 trc_rd_addr;
    logic [XLEN-1:0]            trc_rd_wdata;
    logic [$clog2(DEPTH):0]     trc_count;
    logic                       trc_overflow;
    logic [15:0]                trc_dropped;
`ifdef CORE_RVFI_TRACE_PC_CHECK_EN
    logic                       trc_pc_err;
    logic [63:0]                trc_pc_err_order;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trc_ready,
        input  trc_valid, trc_order, trc_insn, trc_trap, trc_intr, trc_pc_rdata,
               trc_pc_wdata, trc_rd_addr, trc_rd_wdata, trc_count, trc_overflow,
               trc_dropped, trc_pc_err, trc_pc_err_order
    );
    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trc_ready,
        output trc_valid, trc_order, trc_insn, trc_trap, trc_intr, trc_pc_rdata,
               trc_pc_wdata, trc_rd_addr, trc_rd_wdata, trc_count, trc_overflow,
               trc_dropped, trc_pc_err, trc_pc_err_order
    );
`else
    modport master (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trc_ready,
        input  trc_valid, trc_order, trc_insn, trc_trap, trc_intr, trc_pc_rdata,
               trc_pc_wdata, trc_rd_addr, trc_rd_wdata, trc_count, trc_overflow,
               trc_dropped
    );
    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, trc_ready,
        output trc_valid, trc_order, trc_insn, trc_trap, trc_intr, trc_pc_rdata,
               trc_pc_wdata, trc_rd_addr, trc_rd_wdata, trc_count, trc_overflow,
               trc_dropped
    );
`endif
endinterface

// File: rtl/core_rvfi_trace.sv
// core_rvfi_trace: tags every RVFI retirement with a 64-bit order number and
// queues it in a DEPTH-entry show-ahead FIFO drained over valid/ready.
// Drops on overflow are counted (saturating) and flagged, never silent.
// Optional: define CORE_RVFI_TRACE_PC_CHECK_EN to add a PC-continuity checker
// that runs on the input stream (dropped entries included).
module core_rvfi_trace #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    core_rvfi_trace_if.slave       trc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic            intr;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    entry_t          r_mem [DEPTH];
    logic [63:0]     r_ord;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [15:0]     r_dropped;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    entry_t          w_head;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = (r_count != '0) && trc.trc_ready;
    assign w_push = trc.rvfi_valid && (!w_full || w_pop);
    assign w_drop = trc.rvfi_valid && w_full && !w_pop;

    // Entry storage: written on accepted pushes only, never reset.
    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{order:    r_ord,
                               insn:     trc.rvfi_insn,
                               trap:     trc.rvfi_trap,
                               intr:     trc.rvfi_intr,
                               pc_rdata: trc.rvfi_pc_rdata,
                               pc_wdata: trc.rvfi_pc_wdata,
                               rd_addr:  trc.rvfi_rd_addr,
                               rd_wdata: trc.rvfi_rd_wdata};
        end
    end

    // Order counter, pointers, occupancy and drop status.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_ord      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            if (trc.rvfi_valid) r_ord <= r_ord + 64'd1;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_dropped  <= sat_inc16(r_dropped);
            end
        end
    end

    assign w_head           = r_mem[r_rptr];
    assign trc.trc_valid    = (r_count != '0);
    assign trc.trc_count    = r_count;
    assign trc.trc_overflow = r_overflow;
    assign trc.trc_dropped  = r_dropped;
    assign trc.trc_order    = w_head.order;
    assign trc.trc_insn     = w_head.insn;
    assign trc.trc_trap     = w_head.trap;
    assign trc.trc_intr     = w_head.intr;
    assign trc.trc_pc_rdata = w_head.pc_rdata;
    assign trc.trc_pc_wdata = w_head.pc_wdata;
    assign trc.trc_rd_addr  = w_head.rd_addr;
    assign trc.trc_rd_wdata = w_head.rd_wdata;

`ifdef CORE_RVFI_TRACE_PC_CHECK_EN
    logic [XLEN-1:0] r_last_pc_wdata;
    logic            r_seen;
    logic            r_pc_err;
    logic [63:0]     r_pc_err_order;
    logic            w_pc_mismatch;

    // Trap-handler entries legitimately break continuity, so they are exempt.
    assign w_pc_mismatch = trc.rvfi_valid && r_seen && !trc.rvfi_intr &&
                           (trc.rvfi_pc_rdata != r_last_pc_wdata);

    // Last next-PC is tracked for every retirement, even dropped ones.
    always_ff @(posedge g_clk) begin
        if (trc.rvfi_valid) r_last_pc_wdata <= trc.rvfi_pc_wdata;
    end

    // Sticky error flag; only the first error's order is kept.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_seen         <= 1'b0;
            r_pc_err       <= 1'b0;
            r_pc_err_order <= '0;
        end else begin
            if (trc.rvfi_valid) r_seen <= 1'b1;
            if (w_pc_mismatch) begin
                r_pc_err <= 1'b1;
                if (!r_pc_err) r_pc_err_order <= r_ord;
            end
        end
    end

    assign trc.trc_pc_err       = r_pc_err;
    assign trc.trc_pc_err_order = r_pc_err_order;
`endif
endmodule

// File: tb/tb_core_rvfi_trace.sv
// tb_core_rvfi_trace: directed test of the RVFI trace FIFO with hand-computed
// expectations. The PC-check section is built only with CORE_RVFI_TRACE_PC_CHECK_EN.
module tb_core_rvfi_trace;
    logic g_clk;
    logic g_resetn;
    int   n_tests;
    int   n_fail;

    core_rvfi_trace_if #(.DEPTH(8), .XLEN(64), .ILEN(32)) bus ();

    core_rvfi_trace #(.DEPTH(8), .XLEN(64), .ILEN(32)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .trc      (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        step();
        g_resetn = 1'b1;
    endtask

    task automatic retire(input logic [63:0] pc_r, input logic [63:0] pc_w, input logic intr);
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_insn     = 32'h0000_0013;
        bus.rvfi_intr     = intr;
        bus.rvfi_pc_rdata = pc_r;
        bus.rvfi_pc_wdata = pc_w;
        step();
        bus.rvfi_valid    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        g_resetn          = 1'b0;
        bus.rvfi_valid    = 1'b0;
        bus.rvfi_insn     = '0;
        bus.rvfi_trap     = 1'b0;
        bus.rvfi_intr     = 1'b0;
        bus.rvfi_pc_rdata = '0;
        bus.rvfi_pc_wdata = '0;
        bus.rvfi_rd_addr  = 5'd0;
        bus.rvfi_rd_wdata = '0;
        bus.trc_ready     = 1'b0;
        step();
        step();
        g_resetn = 1'b1;

        // Reset state, plus ready while empty is harmless
        check("rst_valid", 64'(bus.trc_valid), 64'd0);
        check("rst_count", 64'(bus.trc_count), 64'd0);
        check("rst_ovf", 64'(bus.trc_overflow), 64'd0);
        check("rst_drop", 64'(bus.trc_dropped), 64'd0);
        bus.trc_ready = 1'b1;
        step();
        check("idle_ready_count", 64'(bus.trc_count), 64'd0);
        bus.trc_ready = 1'b0;

        // Single retire, one-cycle latency, then pop
        bus.rvfi_rd_addr  = 5'd3;
        bus.rvfi_rd_wdata = 64'h55;
        retire(64'h8000_0000, 64'h8000_0004, 1'b0);
        check("single_valid", 64'(bus.trc_valid), 64'd1);
        check("single_order", bus.trc_order, 64'd0);
        check("single_pc", bus.trc_pc_rdata, 64'h8000_0000);
        check("single_insn", 64'(bus.trc_insn), 64'h13);
        check("single_rd", 64'(bus.trc_rd_addr), 64'd3);
        check("single_pcw", bus.trc_pc_wdata, 64'h8000_0004);
        bus.rvfi_rd_addr  = 5'd0;
        bus.rvfi_rd_wdata = '0;
        bus.trc_ready = 1'b1;
        step();
        check("single_pop_valid", 64'(bus.trc_valid), 64'd0);
        check("single_pop_count", 64'(bus.trc_count), 64'd0);
        bus.trc_ready = 1'b0;

        // Back-to-back with ready held: head is always the newest entry
        do_reset();
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.rvfi_valid    = 1'b1;
            bus.rvfi_insn     = 32'h0000_0013;
            bus.rvfi_pc_rdata = 64'(i * 4);
            step();
            check("b2b_order", bus.trc_order, 64'(i));
            check("b2b_pc", bus.trc_pc_rdata, 64'(i * 4));
            check("b2b_count", 64'(bus.trc_count), 64'd1);
        end
        bus.rvfi_valid = 1'b0;
        step();
        check("b2b_empty", 64'(bus.trc_count), 64'd0);
        check("b2b_ovf", 64'(bus.trc_overflow), 64'd0);
        bus.trc_ready = 1'b0;

        // Overflow: 10 pushes into 8 entries
        do_reset();
        for (int i = 0; i < 10; i++) retire(64'h1000 + 64'(i), 64'h0, 1'b0);
        check("ovf_count", 64'(bus.trc_count), 64'd8);
        check("ovf_flag", 64'(bus.trc_overflow), 64'd1);
        check("ovf_dropped", 64'(bus.trc_dropped), 64'd2);
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_order", bus.trc_order, 64'(i));
            check("ovf_drain_pc", bus.trc_pc_rdata, 64'h1000 + 64'(i));
            step();
        end
        check("ovf_drained", 64'(bus.trc_valid), 64'd0);
        bus.trc_ready = 1'b0;
        retire(64'h2000, 64'h0, 1'b0);
        check("ovf_next_order", bus.trc_order, 64'd10);
        check("ovf_sticky", 64'(bus.trc_overflow), 64'd1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) retire(64'h3000 + 64'(i), 64'h0, 1'b0);
        check("fpp_full", 64'(bus.trc_count), 64'd8);
        bus.trc_ready = 1'b1;
        retire(64'hABC, 64'h0, 1'b0);
        check("fpp_count", 64'(bus.trc_count), 64'd8);
        check("fpp_dropped", 64'(bus.trc_dropped), 64'd0);
        check("fpp_ovf", 64'(bus.trc_overflow), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("fpp_order", bus.trc_order, 64'(i + 1));
            if (i == 7) check("fpp_last_pc", bus.trc_pc_rdata, 64'hABC);
            step();
        end
        check("fpp_empty", 64'(bus.trc_valid), 64'd0);
        bus.trc_ready = 1'b0;

        // Reset mid-stream with an overflowed FIFO and a retire in the reset cycle
        do_reset();
        for (int i = 0; i < 10; i++) retire(64'h4000 + 64'(i), 64'h0, 1'b0);
        check("mid_pre_ovf", 64'(bus.trc_overflow), 64'd1);
        g_resetn       = 1'b0;
        bus.rvfi_valid = 1'b1;
        step();
        bus.rvfi_valid = 1'b0;
        g_resetn       = 1'b1;
        check("mid_count", 64'(bus.trc_count), 64'd0);
        check("mid_valid", 64'(bus.trc_valid), 64'd0);
        check("mid_ovf", 64'(bus.trc_overflow), 64'd0);
        check("mid_dropped", 64'(bus.trc_dropped), 64'd0);
        retire(64'h5000, 64'h0, 1'b0);
        check("mid_next_order", bus.trc_order, 64'd0);
        check("mid_next_count", 64'(bus.trc_count), 64'd1);

`ifdef CORE_RVFI_TRACE_PC_CHECK_EN
        // PC continuity: break with intr=0 is flagged, with intr=1 it is not
        do_reset();
        check("pc_rst_err", 64'(bus.trc_pc_err), 64'd0);
        retire(64'h0FC, 64'h100, 1'b0);
        check("pc_first_ok", 64'(bus.trc_pc_err), 64'd0);
        retire(64'h104, 64'h108, 1'b0);
        check("pc_err", 64'(bus.trc_pc_err), 64'd1);
        check("pc_err_order", bus.trc_pc_err_order, 64'd1);
        retire(64'h200, 64'h204, 1'b0);
        check("pc_err_order_kept", bus.trc_pc_err_order, 64'd1);
        do_reset();
        check("pc_err_cleared", 64'(bus.trc_pc_err), 64'd0);
        retire(64'h0FC, 64'h100, 1'b0);
        retire(64'h104, 64'h108, 1'b1);
        check("pc_intr_ok", 64'(bus.trc_pc_err), 64'd0);
        retire(64'h108, 64'h10C, 1'b0);
        check("pc_cont_ok", 64'(bus.trc_pc_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
